// File: rtl/note_player.sv
// note_player: plays one tone per accepted note on a square-wave buzzer output.
//
// A note is accepted from the source when tran_vld is high while tran_rdy is high.
// The note sounds for NOTE_LEN cycles and is followed by GAP_LEN silent cycles.
// A non-zero tone code sets the beep half-period to volume_in*PRESCALE cycles.
// A tone code of 0 is a rest.
// The tran_end strobe marks the end of the song, and song_done pulses for one
// cycle once that end has taken effect.
//
// Optional feature: define PLAYER_MUTE_EN to add a 'mute' input. Mute forces beep
// low and changes no timing or handshake.
//
// Ports:
//   sysclk     in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   volume_in  in   [9:0] tone code (0 = rest)
//   tran_vld   in   note-valid strobe
//   tran_end   in   end-of-song strobe
//   mute       in   (PLAYER_MUTE_EN only) force beep low
//   tran_rdy   out  player idle and able to accept a note or end strobe
//   beep       out  square-wave buzzer drive
//   busy       out  note or gap in progress
//   song_done  out  one-cycle end-of-song pulse
module note_player #(
  parameter int unsigned NOTE_LEN = 12_500_000,
  parameter int unsigned GAP_LEN  = 500_000,
  parameter int unsigned PRESCALE = 50
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [9:0] volume_in,
  input  logic       tran_vld,
  input  logic       tran_end,
`ifdef PLAYER_MUTE_EN
  input  logic       mute,
`endif
  output logic       tran_rdy,
  output logic       beep,
  output logic       busy,
  output logic       song_done
);

  // The half-period counter must be able to hold the largest code times PRESCALE.
  localparam int unsigned HalfMax = 1023 * PRESCALE;
  localparam int unsigned HalfW   = (HalfMax > 1) ? $clog2(HalfMax + 1) : 1;

  // The note/gap counter runs 0..len-1 and is shared by PLAY and GAP.
  localparam int unsigned CntMax = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] NoteLast = CntW'(NOTE_LEN - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HalfW-1:0] hc_q, hc_d;
  logic [9:0]       vol_q, vol_d;
  logic             beep_q, beep_d;
  logic             pend_q, pend_d;   // tran_end accepted together with the note in flight
  logic             done_q, done_d;

  logic [HalfW-1:0] half_len;
  logic [HalfW-1:0] half_last;

  assign half_len  = HalfW'(vol_q) * HalfW'(PRESCALE);
  assign half_last = half_len - HalfW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hc_d    = hc_q;
    vol_d   = vol_q;
    beep_d  = beep_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        hc_d   = '0;
        beep_d = 1'b0;
        if (tran_vld) begin
          state_d = StPlay;
          vol_d   = volume_in;
          pend_d  = tran_end;
        end else if (tran_end) begin
          done_d = 1'b1;
        end
      end

      StPlay: begin
        if (cnt_q == NoteLast) begin
          // Last sounding cycle: beep is forced low from the next cycle on.
          cnt_d  = '0;
          hc_d   = '0;
          beep_d = 1'b0;
          if (GAP_LEN == 0) begin
            state_d = StIdle;
            done_d  = pend_q;
            pend_d  = 1'b0;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (vol_q != '0) begin
            if (hc_q == half_last) begin
              hc_d   = '0;
              beep_d = ~beep_q;
            end else begin
              hc_d = hc_q + 1'b1;
            end
          end
        end
      end

      StGap: begin
        beep_d = 1'b0;
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = pend_q;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        beep_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hc_q    <= '0;
      vol_q   <= '0;
      beep_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      vol_q   <= vol_d;
      beep_q  <= beep_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign tran_rdy  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign song_done = done_q;

`ifdef PLAYER_MUTE_EN
  assign beep = beep_q & ~mute;
`else
  assign beep = beep_q;
`endif

endmodule
